// File: rtl/seg7_pkg.sv
// Shared character codes and active-low segment patterns for the scrolling 7-segment driver.
package seg7_pkg;

   localparam int unsigned CODE_W = 5;
   localparam int unsigned SEG_W  = 8;

   // Character codes
   localparam logic [CODE_W-1:0] CH_0     = 5'h00;
   localparam logic [CODE_W-1:0] CH_1     = 5'h01;
   localparam logic [CODE_W-1:0] CH_2     = 5'h02;
   localparam logic [CODE_W-1:0] CH_3     = 5'h03;
   localparam logic [CODE_W-1:0] CH_4     = 5'h04;
   localparam logic [CODE_W-1:0] CH_5     = 5'h05;
   localparam logic [CODE_W-1:0] CH_6     = 5'h06;
   localparam logic [CODE_W-1:0] CH_7     = 5'h07;
   localparam logic [CODE_W-1:0] CH_8     = 5'h08;
   localparam logic [CODE_W-1:0] CH_9     = 5'h09;
   localparam logic [CODE_W-1:0] CH_A     = 5'h0A;
   localparam logic [CODE_W-1:0] CH_B     = 5'h0B;
   localparam logic [CODE_W-1:0] CH_C     = 5'h0C;
   localparam logic [CODE_W-1:0] CH_D     = 5'h0D;
   localparam logic [CODE_W-1:0] CH_E     = 5'h0E;
   localparam logic [CODE_W-1:0] CH_F     = 5'h0F;
   localparam logic [CODE_W-1:0] CH_BLANK = 5'h10;
   localparam logic [CODE_W-1:0] CH_R     = 5'h11;
   localparam logic [CODE_W-1:0] CH_H     = 5'h12;
   localparam logic [CODE_W-1:0] CH_P     = 5'h13;
   localparam logic [CODE_W-1:0] CH_I     = 5'h14;
   localparam logic [CODE_W-1:0] CH_DASH  = 5'h15;

   // Segment patterns: bit 7 = a ... bit 1 = g, bit 0 = h (dp); 0 lights the segment
   localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
   localparam logic [SEG_W-1:0] SEG_0     = 8'h03;
   localparam logic [SEG_W-1:0] SEG_1     = 8'h9F;
   localparam logic [SEG_W-1:0] SEG_2     = 8'h25;
   localparam logic [SEG_W-1:0] SEG_3     = 8'h0D;
   localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
   localparam logic [SEG_W-1:0] SEG_5     = 8'h49;
   localparam logic [SEG_W-1:0] SEG_6     = 8'h41;
   localparam logic [SEG_W-1:0] SEG_7     = 8'h1F;
   localparam logic [SEG_W-1:0] SEG_8     = 8'h01;
   localparam logic [SEG_W-1:0] SEG_9     = 8'h09;
   localparam logic [SEG_W-1:0] SEG_A     = 8'h11;
   localparam logic [SEG_W-1:0] SEG_B     = 8'hC1;
   localparam logic [SEG_W-1:0] SEG_C     = 8'h63;
   localparam logic [SEG_W-1:0] SEG_D     = 8'h85;
   localparam logic [SEG_W-1:0] SEG_E     = 8'h61;
   localparam logic [SEG_W-1:0] SEG_F     = 8'h71;
   localparam logic [SEG_W-1:0] SEG_R     = 8'hF5;
   localparam logic [SEG_W-1:0] SEG_H     = 8'hD1;
   localparam logic [SEG_W-1:0] SEG_P     = 8'h31;
   localparam logic [SEG_W-1:0] SEG_I     = 8'hF3;
   localparam logic [SEG_W-1:0] SEG_DASH  = 8'hFD;

endpackage

// File: rtl/seg7_char_rom.sv
// Combinational character-code to active-low segment pattern lookup.
module seg7_char_rom
   import seg7_pkg::*;
(
   input  logic [CODE_W-1:0] i_code,
   output logic [SEG_W-1:0]  o_seg_c
);

   // Map each code to its glyph; unassigned codes render blank
   always_comb begin
      o_seg_c = SEG_BLANK;
      case (i_code)
         CH_0:     o_seg_c = SEG_0;
         CH_1:     o_seg_c = SEG_1;
         CH_2:     o_seg_c = SEG_2;
         CH_3:     o_seg_c = SEG_3;
         CH_4:     o_seg_c = SEG_4;
         CH_5:     o_seg_c = SEG_5;
         CH_6:     o_seg_c = SEG_6;
         CH_7:     o_seg_c = SEG_7;
         CH_8:     o_seg_c = SEG_8;
         CH_9:     o_seg_c = SEG_9;
         CH_A:     o_seg_c = SEG_A;
         CH_B:     o_seg_c = SEG_B;
         CH_C:     o_seg_c = SEG_C;
         CH_D:     o_seg_c = SEG_D;
         CH_E:     o_seg_c = SEG_E;
         CH_F:     o_seg_c = SEG_F;
         CH_BLANK: o_seg_c = SEG_BLANK;
         CH_R:     o_seg_c = SEG_R;
         CH_H:     o_seg_c = SEG_H;
         CH_P:     o_seg_c = SEG_P;
         CH_I:     o_seg_c = SEG_I;
         CH_DASH:  o_seg_c = SEG_DASH;
         default:  o_seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scroll_driver.sv
// Multiplexed 7-segment driver with an append-only message buffer that scrolls when longer than the display.
module seg7_scroll_driver
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned MSG_LEN     = 8,
   parameter int unsigned REFRESH_DIV = 65536,
   parameter int unsigned SCROLL_DIV  = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_valid,
   input  logic [4:0]        wr_char,
   output logic              wr_ready,
   input  logic              clear,
   input  logic              scroll_en,
   output logic [7:0]        abcdefgh,
   output logic [DIGITS-1:0] digit
);

   localparam int unsigned REF_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = $clog2(DIGITS);
   localparam int unsigned FRM_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int unsigned LEN_W = $clog2(MSG_LEN + 1);
   localparam int unsigned PTR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int unsigned SUM_W = LEN_W + 1;

   logic [REF_W-1:0]  r_ref_cnt;
   logic [IDX_W-1:0]  r_scan_idx;
   logic [FRM_W-1:0]  r_frame_cnt;
   logic [LEN_W-1:0]  r_len;
   logic [PTR_W-1:0]  r_offset;
   logic [CODE_W-1:0] r_buf [MSG_LEN];
   logic [DIGITS-1:0] r_digit;
   logic [SEG_W-1:0]  r_seg;

   logic              w_tick;
   logic              w_started;
   logic              w_frame_end;
   logic              w_scrolling;
   logic              w_wr_ready;
   logic [IDX_W-1:0]  w_next_idx;
   logic [DIGITS-1:0] w_digit_nxt;
   logic [SUM_W-1:0]  w_sum;
   logic [CODE_W-1:0] w_code;
   logic [SEG_W-1:0]  w_pattern;

   // Digit enables stay all-high between reset and the first refresh tick
   assign w_tick      = (r_ref_cnt == REF_W'(REFRESH_DIV - 1));
   assign w_started   = ~&r_digit;
   assign w_frame_end = w_tick && w_started && (r_scan_idx == IDX_W'(DIGITS - 1));
   assign w_scrolling = scroll_en && (r_len > LEN_W'(DIGITS));
   assign w_wr_ready  = reset_n && (r_len < LEN_W'(MSG_LEN)) && !clear;
   assign wr_ready    = w_wr_ready;
   assign digit       = r_digit;
   assign abcdefgh    = r_seg;

   // Scan index for the slot that begins at this tick; the first tick after reset selects 0
   always_comb begin
      w_next_idx = '0;
      if (w_started && (r_scan_idx != IDX_W'(DIGITS - 1)))
         w_next_idx = r_scan_idx + IDX_W'(1);
      w_digit_nxt = ~(DIGITS'(1) << (IDX_W'(DIGITS - 1) - w_next_idx));
   end

   // Character shown at the current scan position, rotated by the offset while scrolling
   always_comb begin
      w_sum  = SUM_W'(r_offset) + SUM_W'(r_scan_idx);
      w_code = CH_BLANK;
      if (r_len > LEN_W'(DIGITS)) begin
         if (w_sum >= SUM_W'(r_len))
            w_sum = w_sum - SUM_W'(r_len);
         w_code = r_buf[PTR_W'(w_sum)];
      end else if (LEN_W'(r_scan_idx) < r_len) begin
         w_code = r_buf[PTR_W'(r_scan_idx)];
      end
   end

   seg7_char_rom u_rom (
      .i_code  (w_code),
      .o_seg_c (w_pattern)
   );

   // Refresh counter, scan index and registered outputs with a blank first cycle per slot
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ref_cnt  <= '0;
         r_scan_idx <= '0;
         r_digit    <= '1;
         r_seg      <= SEG_BLANK;
      end else if (w_tick) begin
         r_ref_cnt  <= '0;
         r_scan_idx <= w_next_idx;
         r_digit    <= w_digit_nxt;
         r_seg      <= SEG_BLANK;
      end else begin
         r_ref_cnt  <= r_ref_cnt + REF_W'(1);
         r_seg      <= w_started ? w_pattern : SEG_BLANK;
      end
   end

   // Append-only message buffer; clear beats a simultaneous write
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_len <= '0;
      end else if (clear) begin
         r_len <= '0;
      end else if (wr_valid && w_wr_ready) begin
         r_buf[PTR_W'(r_len)] <= wr_char;
         r_len                <= r_len + LEN_W'(1);
      end
   end

   // Scroll offset advances only at frame ends so a frame never mixes offsets
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_offset    <= '0;
         r_frame_cnt <= '0;
      end else if (clear) begin
         r_offset    <= '0;
         r_frame_cnt <= '0;
      end else if (w_frame_end && w_scrolling) begin
         if (r_frame_cnt == FRM_W'(SCROLL_DIV - 1)) begin
            r_frame_cnt <= '0;
            if ((LEN_W'(r_offset) + LEN_W'(1)) == r_len)
               r_offset <= '0;
            else
               r_offset <= r_offset + PTR_W'(1);
         end else begin
            r_frame_cnt <= r_frame_cnt + FRM_W'(1);
         end
      end
   end

endmodule
